// File: rtl/mul_add_pkg.sv
// Shared widths and helpers for the signed pipelined multiply-add.
package mul_add_pkg;

  localparam int unsigned DEF_A_WIDTH = 32;
  localparam int unsigned DEF_B_WIDTH = 24;
  localparam int unsigned DEF_C_WIDTH = 24;
  localparam int unsigned P_WIDTH     = DEF_A_WIDTH + DEF_B_WIDTH;

  // Edges from operand capture to result register, inclusive of both ends.
  function automatic int unsigned mul_add_latency(input int unsigned b_width);
    return b_width + 32'd2;
  endfunction

  function automatic int unsigned mul_add_p_width(input int unsigned a_width,
                                                  input int unsigned b_width);
    return a_width + b_width;
  endfunction

endpackage

// File: rtl/mul_add_stage.sv
// One shift-add stage: folds |a| << BIT_IDX into the partial sum when bit BIT_IDX of |b| is set.
module mul_add_stage
  import mul_add_pkg::*;
#(
  parameter int unsigned A_WIDTH   = DEF_A_WIDTH,
  parameter int unsigned B_WIDTH   = DEF_B_WIDTH,
  parameter int unsigned SUM_WIDTH = DEF_A_WIDTH + DEF_B_WIDTH,
  parameter int unsigned BIT_IDX   = 0
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 up_valid,
  input  logic [A_WIDTH-1:0]   up_mag_a,
  input  logic [B_WIDTH-1:0]   up_mag_b,
  input  logic                 up_sign,
  input  logic [SUM_WIDTH-1:0] up_c_ext,
  input  logic [SUM_WIDTH-1:0] up_sum,
  output logic                 dn_valid,
  output logic [A_WIDTH-1:0]   dn_mag_a,
  output logic [B_WIDTH-1:0]   dn_mag_b,
  output logic                 dn_sign,
  output logic [SUM_WIDTH-1:0] dn_c_ext,
  output logic [SUM_WIDTH-1:0] dn_sum
);

  logic [SUM_WIDTH-1:0] shifted_a;

  assign shifted_a = SUM_WIDTH'(up_mag_a) << BIT_IDX;

  // Valid always advances; payload only moves with a valid token so bubbles leave it untouched.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      dn_valid <= 1'b0;
      dn_mag_a <= '0;
      dn_mag_b <= '0;
      dn_sign  <= 1'b0;
      dn_c_ext <= '0;
      dn_sum   <= '0;
    end else begin
      dn_valid <= up_valid;
      if (up_valid) begin
        dn_mag_a <= up_mag_a;
        dn_mag_b <= up_mag_b;
        dn_sign  <= up_sign;
        dn_c_ext <= up_c_ext;
        dn_sum   <= up_mag_b[BIT_IDX] ? (up_sum + shifted_a) : up_sum;
      end
    end
  end

endmodule

// File: rtl/mul_add.sv
// Signed fully pipelined result = a*b + c; reconstructs a dividend from divider outputs.
module mul_add
  import mul_add_pkg::*;
#(
  parameter int unsigned A_WIDTH = DEF_A_WIDTH,
  parameter int unsigned B_WIDTH = DEF_B_WIDTH,
  parameter int unsigned C_WIDTH = DEF_C_WIDTH
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic [A_WIDTH-1:0]           a,
  input  logic [B_WIDTH-1:0]           b,
  input  logic [C_WIDTH-1:0]           c,
  input  logic                         ivalid,
  output logic [A_WIDTH+B_WIDTH-1:0]   result,
  output logic                         ovalid
);

  localparam int unsigned RES_WIDTH = mul_add_p_width(A_WIDTH, B_WIDTH);

  logic                 cap_valid;
  logic [A_WIDTH-1:0]   cap_mag_a;
  logic [B_WIDTH-1:0]   cap_mag_b;
  logic                 cap_sign;
  logic [RES_WIDTH-1:0] cap_c_ext;

  // Index 0 is the capture stage, index k the output of shift-add stage k.
  logic                 chain_valid [B_WIDTH+1];
  logic [A_WIDTH-1:0]   chain_mag_a [B_WIDTH+1];
  logic [B_WIDTH-1:0]   chain_mag_b [B_WIDTH+1];
  logic                 chain_sign  [B_WIDTH+1];
  logic [RES_WIDTH-1:0] chain_c_ext [B_WIDTH+1];
  logic [RES_WIDTH-1:0] chain_sum   [B_WIDTH+1];

  logic [RES_WIDTH-1:0] signed_sum;
  logic                 unused_tail;

  // Capture: magnitudes (most-negative maps to its unsigned magnitude), product sign, sign-extended c.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cap_valid <= 1'b0;
      cap_mag_a <= '0;
      cap_mag_b <= '0;
      cap_sign  <= 1'b0;
      cap_c_ext <= '0;
    end else begin
      cap_valid <= ivalid;
      if (ivalid) begin
        cap_mag_a <= a[A_WIDTH-1] ? (~a + A_WIDTH'(1)) : a;
        cap_mag_b <= b[B_WIDTH-1] ? (~b + B_WIDTH'(1)) : b;
        cap_sign  <= a[A_WIDTH-1] ^ b[B_WIDTH-1];
        cap_c_ext <= {{(RES_WIDTH-C_WIDTH){c[C_WIDTH-1]}}, c};
      end
    end
  end

  assign chain_valid[0] = cap_valid;
  assign chain_mag_a[0] = cap_mag_a;
  assign chain_mag_b[0] = cap_mag_b;
  assign chain_sign[0]  = cap_sign;
  assign chain_c_ext[0] = cap_c_ext;
  assign chain_sum[0]   = '0;

  for (genvar k = 1; k <= B_WIDTH; k++) begin : g_stage
    mul_add_stage #(
      .A_WIDTH   (A_WIDTH),
      .B_WIDTH   (B_WIDTH),
      .SUM_WIDTH (RES_WIDTH),
      .BIT_IDX   (k - 1)
    ) u_stage (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .up_valid (chain_valid[k-1]),
      .up_mag_a (chain_mag_a[k-1]),
      .up_mag_b (chain_mag_b[k-1]),
      .up_sign  (chain_sign[k-1]),
      .up_c_ext (chain_c_ext[k-1]),
      .up_sum   (chain_sum[k-1]),
      .dn_valid (chain_valid[k]),
      .dn_mag_a (chain_mag_a[k]),
      .dn_mag_b (chain_mag_b[k]),
      .dn_sign  (chain_sign[k]),
      .dn_c_ext (chain_c_ext[k]),
      .dn_sum   (chain_sum[k])
    );
  end

  // Magnitudes are spent once the last stage has consumed them.
  assign unused_tail = ^{chain_mag_a[B_WIDTH], chain_mag_b[B_WIDTH]};

  assign signed_sum = chain_sign[B_WIDTH] ? (~chain_sum[B_WIDTH] + RES_WIDTH'(1))
                                          : chain_sum[B_WIDTH];

  // Finish: apply sign and add c; result holds across bubbles.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ovalid <= 1'b0;
      result <= '0;
    end else begin
      ovalid <= chain_valid[B_WIDTH];
      if (chain_valid[B_WIDTH]) begin
        result <= signed_sum + chain_c_ext[B_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_mul_add.sv
// Directed bench for mul_add at default widths (32 x 24 + 24, latency 26).
module tb_mul_add;
  import mul_add_pkg::*;

  localparam int unsigned LAT = mul_add_latency(DEF_B_WIDTH);

  logic                sys_clk = 1'b0;
  logic                sys_rst;
  logic [31:0]         a;
  logic [23:0]         b;
  logic [23:0]         c;
  logic                ivalid;
  logic [P_WIDTH-1:0]  result;
  logic                ovalid;

  int errors = 0;
  int checks = 0;

  mul_add u_dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .a       (a),
    .b       (b),
    .c       (c),
    .ivalid  (ivalid),
    .result  (result),
    .ovalid  (ovalid)
  );

  always #5 sys_clk = ~sys_clk;

  // Present one operand set at a falling edge and move to the next falling edge.
  task automatic put(input logic v, input logic [31:0] av, input logic [23:0] bv,
                     input logic [23:0] cv);
    ivalid = v;
    a      = av;
    b      = bv;
    c      = cv;
    @(negedge sys_clk);
  endtask

  task automatic idle(input int n);
    ivalid = 1'b0;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic chk(input string tag, input logic v_exp, input logic [P_WIDTH-1:0] r_exp);
    checks++;
    assert (ovalid === v_exp) else begin
      errors++;
      $error("FAIL %s ovalid observed=%0b expected=%0b", tag, ovalid, v_exp);
    end
    checks++;
    assert (result === r_exp) else begin
      errors++;
      $error("FAIL %s result observed=%0h expected=%0h", tag, result, r_exp);
    end
  endtask

  initial begin
    // Reset held with live operands: nothing may emerge.
    sys_rst = 1'b1;
    ivalid  = 1'b1;
    a       = 32'd5;
    b       = 24'd3;
    c       = 24'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      chk("reset_hold", 1'b0, '0);
    end
    sys_rst = 1'b0;
    ivalid  = 1'b0;
    for (int i = 0; i < int'(LAT); i++) begin
      @(negedge sys_clk);
      chk("reset_after", 1'b0, '0);
    end

    // Positive back-to-back stream (divider reconstruction).
    put(1'b1, 32'd17, 24'd7,  24'd4);
    put(1'b1, 32'd17, 24'd25, 24'd10);
    put(1'b1, 32'd3,  24'd6,  24'd0);
    put(1'b1, 32'd62, 24'd5,  24'd3);
    idle(int'(LAT) - 1 - 4);
    chk("pos_pre", 1'b0, '0);
    @(negedge sys_clk); chk("pos_0", 1'b1, 56'd123);
    @(negedge sys_clk); chk("pos_1", 1'b1, 56'd435);
    @(negedge sys_clk); chk("pos_2", 1'b1, 56'd18);
    @(negedge sys_clk); chk("pos_3", 1'b1, 56'd313);
    @(negedge sys_clk); chk("pos_post", 1'b0, 56'd313);

    // Signed mixes and extremes as one stream.
    put(1'b1, 32'(-17),      24'd7,        24'(-4));
    put(1'b1, 32'd19,        24'(-17),     24'(-16));
    put(1'b1, 32'd105,       24'(-8),      24'(-2));
    put(1'b1, 32'(-84),      24'(-3),      24'd0);
    put(1'b1, 32'h8000_0000, 24'h80_0000,  24'd0);
    put(1'b1, 32'h7FFF_FFFF, 24'h7F_FFFF,  24'h7F_FFFF);
    put(1'b1, 32'd0,         24'hFF_FFFF,  24'(-5));
    idle(int'(LAT) - 1 - 7);
    chk("mix_pre", 1'b0, 56'd313);
    @(negedge sys_clk); chk("mix_neg_a", 1'b1, 56'(-123));
    @(negedge sys_clk); chk("mix_neg_b", 1'b1, 56'(-339));
    @(negedge sys_clk); chk("mix_neg_b2", 1'b1, 56'(-842));
    @(negedge sys_clk); chk("mix_neg_ab", 1'b1, 56'd252);
    @(negedge sys_clk); chk("ext_min", 1'b1, 56'h40_0000_0000_0000);
    @(negedge sys_clk); chk("ext_max", 1'b1, 56'h3F_FFFF_8000_0000);
    @(negedge sys_clk); chk("ext_zero_a", 1'b1, 56'(-5));
    @(negedge sys_clk); chk("mix_post", 1'b0, 56'(-5));

    // Bubbles carry junk operands that must not reach the result.
    put(1'b1, 32'd2,    24'd3,    24'd1);
    put(1'b0, 32'd77,   24'd77,   24'd77);
    put(1'b1, 32'd10,   24'(-2),  24'd0);
    put(1'b1, 32'(-5),  24'(-5),  24'd5);
    put(1'b0, 32'd99,   24'd99,   24'd99);
    put(1'b1, 32'd1000, 24'd1000, 24'(-1));
    idle(int'(LAT) - 1 - 6);
    chk("bub_pre", 1'b0, 56'(-5));
    @(negedge sys_clk); chk("bub_0", 1'b1, 56'd7);
    @(negedge sys_clk); chk("bub_gap1", 1'b0, 56'd7);
    @(negedge sys_clk); chk("bub_2", 1'b1, 56'(-20));
    @(negedge sys_clk); chk("bub_3", 1'b1, 56'd30);
    @(negedge sys_clk); chk("bub_gap4", 1'b0, 56'd30);
    @(negedge sys_clk); chk("bub_5", 1'b1, 56'd999999);
    @(negedge sys_clk); chk("bub_post", 1'b0, 56'd999999);

    // Reset lands on the edge of the last of ten inputs; all are discarded.
    for (int i = 0; i < 10; i++) begin
      sys_rst = (i == 9);
      put(1'b1, 32'(i + 1), 24'd2, 24'd0);
    end
    sys_rst = 1'b0;
    ivalid  = 1'b0;
    for (int i = 0; i < int'(LAT); i++) begin
      chk("midrst_quiet", 1'b0, '0);
      @(negedge sys_clk);
    end

    // Fresh operation after the mid-stream reset.
    put(1'b1, 32'(-7), 24'd9, 24'd100);
    idle(int'(LAT) - 2);
    chk("fresh_pre", 1'b0, '0);
    @(negedge sys_clk); chk("fresh", 1'b1, 56'd37);
    @(negedge sys_clk); chk("fresh_post", 1'b0, 56'd37);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
